// File: rtl/mem1_stage_pkg.sv
// mem1_stage_pkg: shared widths, bus layouts and constants for the MEM1 stage.
//   STALL_WD      : stall vector width (bit 4 holds MEM1 input reg, bit 5 holds MEM2)
//   EX2MEM1_WD    : EX->MEM1 bus width
//   MEM12MEM2_WD  : MEM1->MEM2 bus width
//   BYPASS_WD     : MEM1 bypass bus width
//   ST_*          : 2-bit FSM encodings of the data-SRAM request sequencer
//   lane_sel()    : byte-lane select for a given access size and address
package mem1_stage_pkg;

  localparam int STALL_WD     = 6;
  localparam int LSU_WD       = 6;
  localparam int EX2MEM1_WD   = 143;
  localparam int MEM12MEM2_WD = 147;
  localparam int BYPASS_WD    = 38;

  // One-hot access size as carried in lsu_op.size_sel
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  // Request sequencer states
  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_WAIT_GNT = 2'b01;
  localparam logic [1:0] ST_WAIT_RSP = 2'b10;
  localparam logic [1:0] ST_DONE     = 2'b11;

  // lsu_op field order, MSB first
  typedef struct packed {
    logic       en;
    logic       we;
    logic [2:0] size_sel;
    logic       is_unsigned;
  } lsu_op_t;

  typedef struct packed {
    lsu_op_t     lsu_op;
    logic [2:0]  sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] st_data;
    logic [31:0] pc;
    logic [31:0] inst;
  } ex2mem1_t;

  typedef struct packed {
    lsu_op_t     lsu_op;
    logic [3:0]  data_ram_sel;
    logic [2:0]  sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rdata;
  } mem12mem2_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } bypass_t;

  // Byte lanes touched by an access; halfword ignores addr[0] (no misalign trap)
  function automatic logic [3:0] lane_sel(input logic [2:0] size_sel,
                                          input logic [1:0] addr_lo);
    logic [3:0] sel;
    case (size_sel)
      SIZE_BYTE: sel = 4'b0001 << addr_lo;
      SIZE_HALF: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: sel = 4'b1111;
      default:   sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem1_stage_lsu_align.sv
// mem1_stage_lsu_align: combinational lane alignment for the data-SRAM request.
//   en, we     : memory-op enable and write flag from lsu_op
//   size_sel   : one-hot access size (byte/half/word)
//   addr_lo    : address bits [1:0]
//   st_data    : raw store data from the register file
//   ram_sel    : byte lanes touched by the access (0 when en = 0)
//   be         : byte enables, ram_sel for writes, 0 for reads
//   wdata      : store data replicated onto every lane it may occupy
module mem1_stage_lsu_align
  import mem1_stage_pkg::*;
(
  input  logic        en,
  input  logic        we,
  input  logic [2:0]  size_sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  ram_sel,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  // Lane select and byte enables
  always_comb begin
    ram_sel = 4'b0000;
    be      = 4'b0000;
    if (en) begin
      ram_sel = lane_sel(size_sel, addr_lo);
    end else begin
      ram_sel = 4'b0000;
    end
    if (we) begin
      be = ram_sel;
    end else begin
      be = 4'b0000;
    end
  end

  // Replicate store data so the SRAM picks the right lane via be
  always_comb begin
    wdata = 32'h0000_0000;
    case (size_sel)
      SIZE_BYTE: wdata = {4{st_data[7:0]}};
      SIZE_HALF: wdata = {2{st_data[15:0]}};
      SIZE_WORD: wdata = st_data;
      default:   wdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem1_stage.sv
// mem1_stage: first load/store pipeline stage.
//   clk, rst_n        : clock, synchronous active-low reset
//   stall             : stall vector (bit 4 holds this stage, bit 5 holds MEM2)
//   ex2mem1_bus       : EX->MEM1 bus
//   mem12mem2_bus     : MEM1->MEM2 bus, carries the raw read word
//   mem12rf_bus       : bypass bus for non-load results
//   stallreq_mem1     : stall request while a memory op is outstanding
//   data_req..rdata   : data-SRAM req/gnt/rvalid interface
// Each registered memory op issues exactly one request; the op is retired
// (FSM back to IDLE) whenever the input register loads or is bubbled.
module mem1_stage
  import mem1_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX2MEM1_WD-1:0]   ex2mem1_bus,
  output logic [MEM12MEM2_WD-1:0] mem12mem2_bus,
  output logic [BYPASS_WD-1:0]    mem12rf_bus,
  output logic                    stallreq_mem1,
  output logic                    data_req,
  input  logic                    data_gnt,
  output logic                    data_we,
  output logic [3:0]              data_be,
  output logic [31:0]             data_addr,
  output logic [31:0]             data_wdata,
  input  logic                    data_rvalid,
  input  logic [31:0]             data_rdata
);

  ex2mem1_t   ex_r;
  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [31:0] rdata_r;
  logic [31:0] rdata_s;
  logic [3:0] ram_sel_s;
  logic       bubble_s;
  logic       load_s;
  logic       retire_s;
  logic       rsp_now_s;
  mem12mem2_t m2_s;
  bypass_t    bp_s;
  logic       unused_s;

  assign bubble_s  = stall[4] & ~stall[5];
  assign load_s    = ~stall[4];
  assign retire_s  = load_s | bubble_s;
  assign rsp_now_s = (state_r == ST_WAIT_RSP) & data_rvalid;
  assign unused_s  = ^stall[3:0];

  // EX->MEM1 input register: bubble has priority over load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_r <= '0;
    end else if (bubble_s) begin
      ex_r <= '0;
    end else if (load_s) begin
      ex_r <= ex2mem1_bus;
    end else begin
      ex_r <= ex_r;
    end
  end

  // Request sequencer next state; rvalid in WAIT_GNT is ignored by design
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ex_r.lsu_op.en) begin
          state_nxt_s = data_gnt ? ST_WAIT_RSP : ST_WAIT_GNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_GNT: begin
        if (data_gnt) begin
          state_nxt_s = ST_WAIT_RSP;
        end else begin
          state_nxt_s = ST_WAIT_GNT;
        end
      end
      ST_WAIT_RSP: begin
        if (data_rvalid) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT_RSP;
        end
      end
      ST_DONE:  state_nxt_s = ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state; a retiring op always restarts the next one from IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (retire_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read-word holding register, needed while MEM2 is stalled in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (retire_s) begin
      rdata_r <= 32'h0000_0000;
    end else if (rsp_now_s) begin
      rdata_r <= data_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  mem1_stage_lsu_align u_align (
    .en       (ex_r.lsu_op.en),
    .we       (ex_r.lsu_op.we),
    .size_sel (ex_r.lsu_op.size_sel),
    .addr_lo  (ex_r.ex_result[1:0]),
    .st_data  (ex_r.st_data),
    .ram_sel  (ram_sel_s),
    .be       (data_be),
    .wdata    (data_wdata)
  );

  // Request and stall handshake outputs
  always_comb begin
    data_req      = 1'b0;
    stallreq_mem1 = 1'b0;
    if (ex_r.lsu_op.en) begin
      data_req      = (state_r == ST_IDLE) | (state_r == ST_WAIT_GNT);
      stallreq_mem1 = (state_r == ST_IDLE) | (state_r == ST_WAIT_GNT) |
                      ((state_r == ST_WAIT_RSP) & ~data_rvalid);
    end else begin
      data_req      = 1'b0;
      stallreq_mem1 = 1'b0;
    end
  end

  assign data_we   = ex_r.lsu_op.en & ex_r.lsu_op.we;
  assign data_addr = {ex_r.ex_result[31:2], 2'b00};

  // Forward the response in the cycle it arrives so the best case costs one stall
  assign rdata_s = rsp_now_s ? data_rdata : rdata_r;

  // Downstream and bypass bus assembly
  always_comb begin
    m2_s.lsu_op       = ex_r.lsu_op;
    m2_s.data_ram_sel = ram_sel_s;
    m2_s.sel_rf_res   = ex_r.sel_rf_res;
    m2_s.rf_we        = ex_r.rf_we;
    m2_s.rf_waddr     = ex_r.rf_waddr;
    m2_s.ex_result    = ex_r.ex_result;
    m2_s.pc           = ex_r.pc;
    m2_s.inst         = ex_r.inst;
    m2_s.rdata        = rdata_s;
    // sel_rf_res[1] marks a load result, which is not ready until MEM2
    bp_s.rf_we        = ex_r.rf_we & ~ex_r.sel_rf_res[1];
    bp_s.rf_waddr     = ex_r.rf_waddr;
    bp_s.ex_result    = ex_r.ex_result;
  end

  assign mem12mem2_bus = m2_s;
  assign mem12rf_bus   = bp_s;

endmodule

// File: tb/tb_mem1_stage.sv
module tb_mem1_stage;
  import mem1_stage_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [STALL_WD-1:0]     stall;
  logic [EX2MEM1_WD-1:0]   ex2mem1_bus = '0;
  logic [MEM12MEM2_WD-1:0] mem12mem2_bus;
  logic [BYPASS_WD-1:0]    mem12rf_bus;
  logic                    stallreq_mem1;
  logic                    data_req;
  logic                    data_gnt = 1'b0;
  logic                    data_we;
  logic [3:0]              data_be;
  logic [31:0]             data_addr;
  logic [31:0]             data_wdata;
  logic                    data_rvalid = 1'b0;
  logic [31:0]             data_rdata = 32'h0;

  logic ds_stall = 1'b0;
  logic bubble   = 1'b0;

  int checks = 0;
  int errors = 0;
  int stall_cycles = 0;
  int req_cycles = 0;
  int hs_count = 0;

  int          wait_left = 0;
  int          rsp_cnt = 0;
  int          rsp_delay = 1;
  logic [31:0] rsp_data = 32'h0;

  typedef struct { logic [146:0] m2; logic [37:0] rf; } m2_exp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } req_exp_t;
  m2_exp_t  m2_q[$];
  req_exp_t req_q[$];

  // Simple stall controller: hold both stages while MEM1 requests a stall
  assign stall = {ds_stall | stallreq_mem1, ds_stall | stallreq_mem1 | bubble, 4'b0000};

  mem1_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .ex2mem1_bus   (ex2mem1_bus),
    .mem12mem2_bus (mem12mem2_bus),
    .mem12rf_bus   (mem12rf_bus),
    .stallreq_mem1 (stallreq_mem1),
    .data_req      (data_req),
    .data_gnt      (data_gnt),
    .data_we       (data_we),
    .data_be       (data_be),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rvalid   (data_rvalid),
    .data_rdata    (data_rdata)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [142:0] mk_ex(input logic [5:0] lsu, input logic [2:0] sel,
      input logic we, input logic [4:0] wa, input logic [31:0] ex, input logic [31:0] st,
      input logic [31:0] pc, input logic [31:0] inst);
    return {lsu, sel, we, wa, ex, st, pc, inst};
  endfunction

  task automatic push_m2(input logic [5:0] lsu, input logic [3:0] ram_sel, input logic [2:0] sel,
      input logic we, input logic [4:0] wa, input logic [31:0] ex, input logic [31:0] pc,
      input logic [31:0] inst, input logic [31:0] rdata, input logic bp_we);
    m2_exp_t e;
    e.m2 = {lsu, ram_sel, sel, we, wa, ex, pc, inst, rdata};
    e.rf = {bp_we, wa, ex};
    m2_q.push_back(e);
  endtask

  task automatic push_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
      input logic [31:0] wdata);
    req_exp_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_slave(input int gwait, input int delay, input logic [31:0] data);
    wait_left = gwait;
    rsp_delay = delay;
    rsp_data  = data;
  endtask

  task automatic clr_cnt();
    stall_cycles = 0;
    req_cycles   = 0;
    hs_count     = 0;
  endtask

  // Present an op and return once the input register has taken it
  task automatic send(input logic [142:0] b);
    int n = 0;
    ex2mem1_bus = b;
    while (stall[4] && n < 100) begin
      step();
      n++;
    end
    chk("send_bound", 192'(n >= 100), 192'(0));
    step();
  endtask

  task automatic drain();
    int n = 0;
    while ((m2_q.size() != 0 || req_q.size() != 0) && n < 50) begin
      step();
      n++;
    end
    chk("drain_bound", 192'(n >= 50), 192'(0));
    m2_q.delete();
    req_q.delete();
    step();
    step();
  endtask

  // Data-SRAM slave: grants after wait_left request cycles, responds rsp_delay cycles later
  initial begin
    forever begin
      @(negedge clk);
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt = rsp_cnt - 1;
        if (rsp_cnt == 0) begin
          data_rvalid = 1'b1;
          data_rdata  = rsp_data;
        end
      end else if (data_req) begin
        if (wait_left > 0) begin
          wait_left = wait_left - 1;
        end else begin
          data_gnt = 1'b1;
          rsp_cnt  = rsp_delay;
        end
      end
    end
  end

  // Monitor: pops expected requests on handshakes and expected MEM2 words on transfer
  initial begin
    req_exp_t r;
    m2_exp_t  e;
    forever begin
      @(negedge clk);
      #2;
      if (stallreq_mem1) stall_cycles++;
      if (data_req) req_cycles++;
      if (data_req && data_gnt) begin
        hs_count++;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %0h expected no request", data_addr);
        end else begin
          r = req_q.pop_front();
          chk("req_we", 192'(data_we), 192'(r.we));
          chk("req_be", 192'(data_be), 192'(r.be));
          chk("req_addr", 192'(data_addr), 192'(r.addr));
          chk("req_wdata", 192'(data_wdata), 192'(r.wdata));
        end
      end
      if (rst_n && !stall[5] && !stallreq_mem1 && mem12mem2_bus[63:32] != 32'h0) begin
        if (m2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_m2: got %0h expected nothing", mem12mem2_bus);
        end else begin
          e = m2_q.pop_front();
          chk("m2_bus", 192'(mem12mem2_bus), 192'(e.m2));
          chk("rf_bus", 192'(mem12rf_bus), 192'(e.rf));
        end
      end
    end
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_m2", 192'(mem12mem2_bus), 192'(0));
    chk("rst_rf", 192'(mem12rf_bus), 192'(0));
    chk("rst_ctl", 192'({stallreq_mem1, data_req, data_we, data_be}), 192'(0));
    chk("rst_addr_wdata", 192'({data_addr, data_wdata}), 192'(0));
    rst_n = 1'b1;
    step();

    // lb at 0x1003, immediate gnt, rvalid next cycle
    clr_cnt();
    cfg_slave(0, 1, 32'hAABBCCDD);
    push_req(1'b0, 4'b0000, 32'h0000_1000, 32'h0000_0000);
    push_m2(6'b100010, 4'b1000, 3'b010, 1'b1, 5'd3, 32'h0000_1003, 32'h0000_0100,
            32'h0000_1003, 32'hAABBCCDD, 1'b0);
    send(mk_ex(6'b100010, 3'b010, 1'b1, 5'd3, 32'h0000_1003, 32'h0, 32'h0000_0100, 32'h0000_1003));
    ex2mem1_bus = '0;
    drain();
    chk("lb_stall_cycles", 192'(stall_cycles), 192'(1));
    chk("lb_req_count", 192'(hs_count), 192'(1));

    // sh of 0x1234 at 0x2002, ack two cycles after gnt
    clr_cnt();
    cfg_slave(0, 2, 32'h0000_0000);
    push_req(1'b1, 4'b1100, 32'h0000_2000, 32'h1234_1234);
    push_m2(6'b110100, 4'b1100, 3'b000, 1'b0, 5'd0, 32'h0000_2002, 32'h0000_0104,
            32'h0000_2002, 32'h0000_0000, 1'b0);
    send(mk_ex(6'b110100, 3'b000, 1'b0, 5'd0, 32'h0000_2002, 32'h0000_1234, 32'h0000_0104, 32'h0000_2002));
    ex2mem1_bus = '0;
    drain();
    chk("sh_stall_cycles", 192'(stall_cycles), 192'(2));
    chk("sh_req_count", 192'(hs_count), 192'(1));

    // lw with gnt withheld 3 cycles, rvalid 2 cycles after gnt
    clr_cnt();
    cfg_slave(3, 2, 32'hCAFEF00D);
    push_req(1'b0, 4'b0000, 32'h0000_3004, 32'h0000_0000);
    push_m2(6'b101000, 4'b1111, 3'b010, 1'b1, 5'd5, 32'h0000_3004, 32'h0000_0108,
            32'h0000_3004, 32'hCAFEF00D, 1'b0);
    send(mk_ex(6'b101000, 3'b010, 1'b1, 5'd5, 32'h0000_3004, 32'h0, 32'h0000_0108, 32'h0000_3004));
    ex2mem1_bus = '0;
    drain();
    chk("gntwait_req_cycles", 192'(req_cycles), 192'(4));
    chk("gntwait_stall_cycles", 192'(stall_cycles), 192'(5));
    chk("gntwait_req_count", 192'(hs_count), 192'(1));

    // lw completing while MEM2 is stalled
    clr_cnt();
    cfg_slave(0, 1, 32'h11223344);
    push_req(1'b0, 4'b0000, 32'h0000_3010, 32'h0000_0000);
    push_m2(6'b101000, 4'b1111, 3'b010, 1'b1, 5'd6, 32'h0000_3010, 32'h0000_010C,
            32'h0000_3010, 32'h11223344, 1'b0);
    send(mk_ex(6'b101000, 3'b010, 1'b1, 5'd6, 32'h0000_3010, 32'h0, 32'h0000_010C, 32'h0000_3010));
    ds_stall = 1'b1;
    ex2mem1_bus = '0;
    for (int i = 0; i < 6; i++) step();
    chk("done_req_count", 192'(hs_count), 192'(1));
    chk("done_no_stallreq", 192'({stallreq_mem1, data_req}), 192'(0));
    chk("done_rdata_held", 192'(mem12mem2_bus[31:0]), 192'(32'h11223344));
    ds_stall = 1'b0;
    drain();
    chk("done_req_count_after", 192'(hs_count), 192'(1));

    // add (no memory op) then lw back to back
    clr_cnt();
    cfg_slave(0, 1, 32'h0BADF00D);
    push_m2(6'b000000, 4'b0000, 3'b000, 1'b1, 5'd7, 32'h0000_0030, 32'h0000_0110,
            32'h0000_0030, 32'h0000_0000, 1'b1);
    push_req(1'b0, 4'b0000, 32'h0000_4000, 32'h0000_0000);
    push_m2(6'b101000, 4'b1111, 3'b010, 1'b1, 5'd8, 32'h0000_4000, 32'h0000_0114,
            32'h0000_4000, 32'h0BADF00D, 1'b0);
    send(mk_ex(6'b000000, 3'b000, 1'b1, 5'd7, 32'h0000_0030, 32'h0, 32'h0000_0110, 32'h0000_0030));
    chk("add_no_stall", 192'({stallreq_mem1, data_req}), 192'(0));
    chk("add_bypass", 192'(mem12rf_bus), 192'({1'b1, 5'd7, 32'h0000_0030}));
    send(mk_ex(6'b101000, 3'b010, 1'b1, 5'd8, 32'h0000_4000, 32'h0, 32'h0000_0114, 32'h0000_4000));
    ex2mem1_bus = '0;
    drain();
    chk("add_lw_stall_cycles", 192'(stall_cycles), 192'(1));

    // sb of 0xA5 at 0x5001, then lhu at 0x6001 (addr[0] ignored)
    cfg_slave(0, 1, 32'h0000_0000);
    push_req(1'b1, 4'b0010, 32'h0000_5000, 32'hA5A5_A5A5);
    push_m2(6'b110010, 4'b0010, 3'b000, 1'b0, 5'd0, 32'h0000_5001, 32'h0000_0118,
            32'h0000_5001, 32'h0000_0000, 1'b0);
    send(mk_ex(6'b110010, 3'b000, 1'b0, 5'd0, 32'h0000_5001, 32'h0000_00A5, 32'h0000_0118, 32'h0000_5001));
    ex2mem1_bus = '0;
    drain();
    cfg_slave(0, 1, 32'h8765_4321);
    push_req(1'b0, 4'b0000, 32'h0000_6000, 32'hBEEF_BEEF);
    push_m2(6'b100101, 4'b0011, 3'b010, 1'b1, 5'd9, 32'h0000_6001, 32'h0000_011C,
            32'h0000_6001, 32'h8765_4321, 1'b0);
    send(mk_ex(6'b100101, 3'b010, 1'b1, 5'd9, 32'h0000_6001, 32'h0000_BEEF, 32'h0000_011C, 32'h0000_6001));
    ex2mem1_bus = '0;
    drain();

    // bubble clears the input register
    push_m2(6'b000000, 4'b0000, 3'b000, 1'b1, 5'd10, 32'h0000_0077, 32'h0000_0120,
            32'h0000_0077, 32'h0000_0000, 1'b1);
    send(mk_ex(6'b000000, 3'b000, 1'b1, 5'd10, 32'h0000_0077, 32'h0, 32'h0000_0120, 32'h0000_0077));
    bubble = 1'b1;
    ex2mem1_bus = '0;
    step();
    chk("bubble_m2", 192'(mem12mem2_bus), 192'(0));
    chk("bubble_rf", 192'(mem12rf_bus), 192'(0));
    bubble = 1'b0;
    drain();

    // reset during WAIT_RSP, late response afterwards
    cfg_slave(0, 3, 32'hFFFF_0000);
    push_req(1'b0, 4'b0000, 32'h0000_7000, 32'h0000_0000);
    send(mk_ex(6'b101000, 3'b010, 1'b1, 5'd11, 32'h0000_7000, 32'h0, 32'h0000_0124, 32'h0000_7000));
    ex2mem1_bus = '0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_ctl", 192'({stallreq_mem1, data_req, data_we, data_be}), 192'(0));
    chk("rst_mid_m2", 192'(mem12mem2_bus), 192'(0));
    chk("rst_mid_rf", 192'(mem12rf_bus), 192'(0));
    rst_n = 1'b1;
    step();
    chk("stray_rvalid_m2", 192'(mem12mem2_bus), 192'(0));
    for (int i = 0; i < 3; i++) step();
    chk("stray_after_ctl", 192'({stallreq_mem1, data_req}), 192'(0));
    chk("stray_after_m2", 192'(mem12mem2_bus), 192'(0));

    // recovery: lb at 0x1001 behaves normally
    clr_cnt();
    cfg_slave(0, 1, 32'h0102_0304);
    push_req(1'b0, 4'b0000, 32'h0000_1000, 32'h0000_0000);
    push_m2(6'b100010, 4'b0010, 3'b010, 1'b1, 5'd12, 32'h0000_1001, 32'h0000_0128,
            32'h0000_1001, 32'h0102_0304, 1'b0);
    send(mk_ex(6'b100010, 3'b010, 1'b1, 5'd12, 32'h0000_1001, 32'h0, 32'h0000_0128, 32'h0000_1001));
    ex2mem1_bus = '0;
    drain();
    chk("recover_stall_cycles", 192'(stall_cycles), 192'(1));
    chk("recover_req_count", 192'(hs_count), 192'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
